// File: rtl/fifo_ctrl_if.sv
// Requester/memory-side bundle for fifo_ctrl.
// The requester drives push/pop. The controller returns the memory enables,
// the addresses, the flags and the status pulses.
interface fifo_ctrl_if #(
    parameter int ADDR_SIZE = 4
);
    logic                 push;
    logic                 pop;
    logic                 mem_wr_en;
    logic                 mem_rd_en;
    logic [ADDR_SIZE:0]   wr_addr;
    logic [ADDR_SIZE:0]   rd_addr;
    logic                 full;
    logic                 empty;
    logic                 almost_full;
    logic                 almost_empty;
    logic [ADDR_SIZE:0]   count;
    logic                 rd_valid;
    logic                 overflow;
    logic                 underflow;

    // Requester side
    modport master (
        output push, pop,
        input  mem_wr_en, mem_rd_en, wr_addr, rd_addr, full, empty,
               almost_full, almost_empty, count, rd_valid, overflow, underflow
    );

    // Controller side
    modport slave (
        input  push, pop,
        output mem_wr_en, mem_rd_en, wr_addr, rd_addr, full, empty,
               almost_full, almost_empty, count, rd_valid, overflow, underflow
    );
endinterface

// File: rtl/fifo_ctrl.sv
// FIFO pointer/flag controller.
// It qualifies push/pop against full/empty and drives the gated memory enables
// and addresses. It also reports occupancy and flags the cycle in which memory
// read data is valid.
// Optional macro FIFO_CTRL_STICKY_ERR_EN: when defined, overflow/underflow
// hold until reset. Otherwise each is a single-cycle pulse.
module fifo_ctrl #(
    parameter int DEPTH     = 16,
    parameter int ADDR_SIZE = 4,
    parameter int AF_LEVEL  = 12,
    parameter int AE_LEVEL  = 4
) (
    input  logic         clk,
    input  logic         rst,
    fifo_ctrl_if.slave   bus
);
    localparam logic [ADDR_SIZE:0] LP_AF = AF_LEVEL[ADDR_SIZE:0];
    localparam logic [ADDR_SIZE:0] LP_AE = AE_LEVEL[ADDR_SIZE:0];

    // The wrap-bit scheme only works for power-of-two depths.
    if (DEPTH != (1 << ADDR_SIZE)) begin : g_depth_check
        $error("fifo_ctrl: DEPTH must equal 2**ADDR_SIZE");
    end

    logic [ADDR_SIZE:0] r_wr_ptr;
    logic [ADDR_SIZE:0] r_rd_ptr;
    logic               r_rd_valid;
    logic               r_overflow;
    logic               r_underflow;

    logic               w_full;
    logic               w_empty;
    logic               w_wr_ok;
    logic               w_rd_ok;
    logic               w_wr_en;
    logic               w_rd_en;
    logic [ADDR_SIZE:0] w_count;

    // Flags come straight from the registered pointers.
    // The wrap bit tells full apart from empty when the low bits match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_SIZE-1:0] == r_rd_ptr[ADDR_SIZE-1:0]) &&
                     (r_wr_ptr[ADDR_SIZE]     != r_rd_ptr[ADDR_SIZE]);

    // A push while full is accepted when a pop frees the slot on the same edge.
    // A pop while empty is never accepted.
    assign w_wr_ok = !w_full | bus.pop;
    assign w_rd_ok = !w_empty;
    assign w_wr_en = bus.push & w_wr_ok;
    assign w_rd_en = bus.pop  & w_rd_ok;

    // Modular pointer difference gives occupancy 0..DEPTH without a separate counter.
    assign w_count = r_wr_ptr - r_rd_ptr;

    assign bus.mem_wr_en    = w_wr_en;
    assign bus.mem_rd_en    = w_rd_en;
    assign bus.wr_addr      = {1'b0, r_wr_ptr[ADDR_SIZE-1:0]};
    assign bus.rd_addr      = {1'b0, r_rd_ptr[ADDR_SIZE-1:0]};
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.count        = w_count;
    assign bus.almost_full  = (w_count >= LP_AF);
    assign bus.almost_empty = (w_count <= LP_AE);
    assign bus.rd_valid     = r_rd_valid;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

    // Advance pointers on accepted requests. Rejected requests leave them untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Mark the cycle in which memory read data is valid. The error flags
    // register rejected requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_en;
`ifdef FIFO_CTRL_STICKY_ERR_EN
            r_overflow  <= r_overflow  | (bus.push & !w_wr_ok);
            r_underflow <= r_underflow | (bus.pop  & !w_rd_ok);
`else
            r_overflow  <= bus.push & !w_wr_ok;
            r_underflow <= bus.pop  & !w_rd_ok;
`endif
        end
    end
endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl.
// A queue-based occupancy model is compared against the DUT on every falling
// edge. Directed literal checks pin the model at key points.
module tb_fifo_ctrl;
    localparam int DEPTH = 16;
    localparam int AS    = 4;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    fifo_ctrl_if #(.ADDR_SIZE(AS)) bus();

    fifo_ctrl #(.DEPTH(DEPTH), .ADDR_SIZE(AS), .AF_LEVEL(12), .AE_LEVEL(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_count;
    int m_wr_total;
    int m_rd_total;
    bit m_rv;
    bit m_ovf;
    bit m_unf;
    int m_q[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_count = 0; m_wr_total = 0; m_rd_total = 0;
            m_rv = 0; m_ovf = 0; m_unf = 0;
            m_q.delete();
        end else begin
            bit acc_w, acc_r;
            acc_w = bus.push && (m_count < DEPTH || bus.pop);
            acc_r = bus.pop && (m_count > 0);
`ifdef FIFO_CTRL_STICKY_ERR_EN
            m_ovf = m_ovf | (bus.push && !acc_w);
            m_unf = m_unf | (bus.pop && !acc_r);
`else
            m_ovf = bus.push && !acc_w;
            m_unf = bus.pop && !acc_r;
`endif
            m_rv = acc_r;
            if (acc_r) begin
                void'(m_q.pop_front());
                m_rd_total++;
            end
            if (acc_w) begin
                m_q.push_back(m_wr_total % DEPTH);
                m_wr_total++;
            end
            m_count = m_count + int'(acc_w) - int'(acc_r);
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge clk) begin
        bit exp_wr, exp_rd;
        exp_wr = bus.push && (m_count < DEPTH || bus.pop);
        exp_rd = bus.pop && (m_count > 0);
        check("mem_wr_en",    32'(bus.mem_wr_en),    32'(exp_wr));
        check("mem_rd_en",    32'(bus.mem_rd_en),    32'(exp_rd));
        check("wr_addr",      32'(bus.wr_addr),      32'(m_wr_total % DEPTH));
        check("rd_addr",      32'(bus.rd_addr),      32'(m_rd_total % DEPTH));
        check("count",        32'(bus.count),        32'(m_count));
        check("full",         32'(bus.full),         32'(m_count == DEPTH));
        check("empty",        32'(bus.empty),        32'(m_count == 0));
        check("almost_full",  32'(bus.almost_full),  32'(m_count >= 12));
        check("almost_empty", 32'(bus.almost_empty), 32'(m_count <= 4));
        check("rd_valid",     32'(bus.rd_valid),     32'(m_rv));
        check("overflow",     32'(bus.overflow),     32'(m_ovf));
        check("underflow",    32'(bus.underflow),    32'(m_unf));
        if (exp_rd && m_q.size() > 0)
            check("rd_addr_order", 32'(bus.rd_addr), 32'(m_q[0]));
    end

    // ---------------- stimulus ----------------
    // Apply one request vector for one clock cycle.
    task automatic step(input bit p, input bit q);
        bus.push = p;
        bus.pop  = q;
        @(posedge clk);
        #1;
    endtask

    // Wrap pattern: 0 idle, 1 push, 2 pop, 3 both; keeps count in 3..5 starting from 4.
    int wrap_pat[8] = '{3, 1, 2, 3, 2, 1, 3, 0};

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst      = 1'b1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        #12 rst = 1'b0;
        @(posedge clk); #1;

        // 1. Asynchronous reset mid-stream with count = 7 and rd_valid high.
        for (int i = 0; i < 8; i++) step(1, 0);
        step(0, 1);
        check("pre_reset_count", 32'(bus.count), 32'd7);
        check("pre_reset_rd_valid", 32'(bus.rd_valid), 32'd1);
        bus.pop = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_count", 32'(bus.count), 32'd0);
        check("async_rst_empty", 32'(bus.empty), 32'd1);
        check("async_rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("async_rst_ae", 32'(bus.almost_empty), 32'd1);
        @(posedge clk); #2 rst = 1'b0;
        @(posedge clk); #1;

        // 2. Fill with 16 pushes. Write addresses run 0..15.
        for (int i = 0; i < 16; i++) begin
            check("fill_wr_addr", 32'(bus.wr_addr), 32'(i));
            check("fill_af", 32'(bus.almost_full), 32'(i >= 12));
            step(1, 0);
        end
        check("fill_count", 32'(bus.count), 32'd16);
        check("fill_full", 32'(bus.full), 32'd1);
        check("fill_wr_addr_wrap", 32'(bus.wr_addr), 32'd0);

        // 3. Overflow: push while full without pop.
        bus.push = 1'b1; bus.pop = 1'b0; #1;
        check("ovf_wr_en", 32'(bus.mem_wr_en), 32'd0);
        @(posedge clk); #1;
        check("ovf_pulse", 32'(bus.overflow), 32'd1);
        check("ovf_count", 32'(bus.count), 32'd16);
        step(0, 0);
`ifdef FIFO_CTRL_STICKY_ERR_EN
        check("ovf_after", 32'(bus.overflow), 32'd1);
`else
        check("ovf_after", 32'(bus.overflow), 32'd0);
`endif

        // 4. Drain 16 pops. Read addresses run 0..15. rd_valid follows each pop.
        for (int i = 0; i < 16; i++) begin
            check("drain_rd_addr", 32'(bus.rd_addr), 32'(i));
            step(0, 1);
            check("drain_rd_valid", 32'(bus.rd_valid), 32'd1);
        end
        check("drain_empty", 32'(bus.empty), 32'd1);
        bus.push = 1'b0; bus.pop = 1'b1; #1;
        check("unf_rd_en", 32'(bus.mem_rd_en), 32'd0);
        @(posedge clk); #1;
        check("unf_pulse", 32'(bus.underflow), 32'd1);
        check("unf_rd_valid", 32'(bus.rd_valid), 32'd0);

        // 5b. Empty with push and pop: only the write is accepted.
        bus.push = 1'b1; bus.pop = 1'b1; #1;
        check("empty_both_wr", 32'(bus.mem_wr_en), 32'd1);
        check("empty_both_rd", 32'(bus.mem_rd_en), 32'd0);
        @(posedge clk); #1;
        check("empty_both_count", 32'(bus.count), 32'd1);
        check("empty_both_unf", 32'(bus.underflow), 32'd1);

        // Refill to full, then 5a. Full with push and pop: both are accepted.
        for (int i = 0; i < 15; i++) step(1, 0);
        check("refill_full", 32'(bus.full), 32'd1);
        bus.push = 1'b1; bus.pop = 1'b1; #1;
        check("full_both_wr", 32'(bus.mem_wr_en), 32'd1);
        check("full_both_rd", 32'(bus.mem_rd_en), 32'd1);
        @(posedge clk); #1;
        check("full_both_count", 32'(bus.count), 32'd16);
        check("full_both_full", 32'(bus.full), 32'd1);
        check("full_both_ovf", 32'(bus.overflow), 32'd0
`ifdef FIFO_CTRL_STICKY_ERR_EN
              | 32'd1
`endif
              );

        // 6. Drain to 4, then 40 interleaved cycles with count held in 3..5.
        for (int i = 0; i < 12; i++) step(0, 1);
        check("wrap_start_count", 32'(bus.count), 32'd4);
        for (int i = 0; i < 40; i++) begin
            int v;
            v = wrap_pat[i % 8];
            step(v[0], v[1]);
            check("wrap_no_full", 32'(bus.full), 32'd0);
            check("wrap_no_empty", 32'(bus.empty), 32'd0);
        end
        check("wrap_end_count", 32'(bus.count), 32'd4);
        step(0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
